mcload: RTL and testbench
=========================

# mcload

Writable microcode control store with a byte-stream loader. A host-side byte stream is packed into 56-bit microinstructions and written into a 1024×56 RAM. The RAM's registered read port is behaviourally identical to the microcode ROM port, so the block drops in where the sequencer fetches microinstructions. Microcode can therefore be loaded or patched at run time instead of only at synthesis.

## Interface
Parameters:
- `AW`, 10, control-store address width (depth 2^AW words).
- `DW`, 56, microinstruction width.
- `BPW`, 7, bytes per word; `DW` = 8·`BPW`.

Ports:
- `clk`, in, 1: single clock for all logic.
- `reset`, in, 1: synchronous, active-high.
- `start`, in, 1: single-cycle load request; sampled only in IDLE.
- `base`, in, AW: first write address; latched on accepted `start`.
- `count`, in, AW+1: number of words to load; latched on `start`; 0 means 2^AW.
- `s_data`, in, 8: stream byte.
- `s_valid`, in, 1: `s_data` is valid.
- `s_ready`, out, 1: loader accepts a byte; byte transfers when `s_valid & s_ready`.
- `busy`, out, 1: load in progress.
- `done`, out, 1: one-cycle pulse after the last word is written.
- `sum`, out, 8: modulo-256 sum of all bytes accepted since the last accepted `start`.
- `ena`, in, 1: read clock enable.
- `addr`, in, AW: read address.
- `data`, out, DW: registered read data.

## Operation
- States: IDLE, LOAD, DONE.
- IDLE → LOAD on `start`. On that transition: latch `base` into the write pointer and `count` into the word counter; clear the byte index and `sum`.
- `start` outside IDLE is ignored.
- LOAD: `s_ready`=1. Each accepted byte:
  - is shifted into the assembly register, first byte into bits [7:0] (little-endian);
  - is added into `sum`;
  - increments the byte index.
- On acceptance of byte index `BPW`−1, in the same edge:
  - RAM[wptr] ← {`s_data`, assembly[47:0]};
  - wptr increments, wrapping 2^AW−1 → 0;
  - word counter decrements and byte index clears.
- When the word counter reaches 0 on that edge: LOAD → DONE.
- DONE: `done`=1 for exactly one cycle, then → IDLE.
- Read port is independent and always active. On an edge with `ena`=1, `data` ← RAM[`addr`]; otherwise `data` holds.
- Same-address read and write on the same edge: `data` returns the old word (read-before-write).
- `s_valid` without `s_ready` is not an error; the byte simply waits.

## Timing
- Reset values: state IDLE, `s_ready`=0, `busy`=0, `done`=0, `sum`=0, `data`=0, internal counters 0.
- Reset does not clear RAM contents. Words already written in an interrupted load remain valid; the partially assembled word is discarded.
- Outputs are decoded from registered state only; no combinational path from stream inputs to `s_ready`.
- `busy` = (state==LOAD).
- Minimum load time for N words: 7N cycles of continuous `s_valid`, plus 1 DONE cycle. `s_ready` first rises the cycle after `start`.
- Last byte accepted at edge E ⇒ `done` high in cycle E..E+1. A read of that word with `ena` at edge E+1 returns the new value.
- Read latency is 1 clock from the `ena` edge, identical to the ROM.

## Structure
- Shared package `mc_pkg` holds:
  - constants `MC_AW`=10, `MC_DW`=56, `MC_BPW`=7;
  - the loader state encoding (IDLE, LOAD, DONE).
- Sub-module `mcram_dp`: simple dual-port RAM, 2^AW×DW, one write port, one registered read port with enable, read-before-write. Infers block RAM.
- `mcload` contains the FSM, assembly register, counters and checksum.

## Test plan
- Single word: `base`=0x010, `count`=1, bytes 01..07 continuous → write at the 7th acceptance; `done` pulses one cycle; read 0x010 gives 0x07060504030201; `sum`=0x1C.
- Wrap: `base`=0x3FF, `count`=2, 14 bytes → words land at 0x3FF and 0x000; 0x001 is unchanged.
- Backpressure gaps: `s_valid` toggles randomly across a 4-word load → identical RAM contents and `sum` as the continuous run; `busy` stays high throughout.
- Start while busy: pulse `start` with a different `base` mid-load → ignored; the original load completes at the original addresses.
- Reset mid-word: assert `reset` after 3 bytes of word 2 → IDLE; word 1 is retained; word 2's address is unchanged; `sum`=0; `data`=0.
- Read/write collision: `ena`=1, `addr`=wptr on the write edge → old data; on the next edge → new data.

Source files
------------

// File: rtl/mc_pkg.sv
// ----------------------------------------------------------------------------
// mc_pkg
// Shared definitions for the writable microcode control store.
//   MC_AW      : control-store address width (depth 2^MC_AW words)
//   MC_DW      : microinstruction width in bits
//   MC_BPW     : stream bytes per microinstruction (MC_DW = 8 * MC_BPW)
//   mc_state_e : loader state encoding (IDLE, LOAD, DONE)
// ----------------------------------------------------------------------------
package mc_pkg;

    localparam int MC_AW  = 10;
    localparam int MC_DW  = 56;
    localparam int MC_BPW = 7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } mc_state_e;

endpackage

// File: rtl/mcram_dp.sv
// ----------------------------------------------------------------------------
// mcram_dp
// Simple dual-port control-store RAM, 2^AW x DW. One synchronous write port
// and one registered read port with clock enable. A read and a write to the
// same address on the same edge return the old word (read-before-write).
// Only the read-data register is reset; the array contents survive reset.
// Ports:
//   clk    : clock
//   reset  : synchronous active-high reset of the read-data register
//   we     : write enable
//   waddr  : write address
//   wdata  : write data
//   ena    : read clock enable
//   raddr  : read address
//   rdata  : registered read data
// ----------------------------------------------------------------------------
module mcram_dp
    import mc_pkg::*;
#(
    parameter int AW = MC_AW,
    parameter int DW = MC_DW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          ena,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem_r [0:(1<<AW)-1];
    logic [DW-1:0] rdata_r;

    // Write port: array has no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    // Read port: old contents are sampled, giving read-before-write.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_r <= {DW{1'b0}};
        end else if (ena) begin
            rdata_r <= mem_r[raddr];
        end
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/mcload.sv
// ----------------------------------------------------------------------------
// mcload
// Writable microcode control store with a byte-stream loader. Stream bytes
// are packed little-endian into DW-bit words and written into a 2^AW x DW
// RAM whose registered read port behaves like the microcode ROM port.
// Ports:
//   clk     : clock
//   reset   : synchronous active-high reset
//   start   : load request, honoured only in IDLE
//   base    : first write address, latched on accepted start
//   count   : words to load, latched on accepted start (0 = 2^AW)
//   s_data  : stream byte
//   s_valid : stream byte valid
//   s_ready : loader accepts a byte (transfer on s_valid & s_ready)
//   busy    : load in progress
//   done    : one-cycle pulse after the last word is written
//   sum     : mod-256 sum of bytes accepted since the last accepted start
//   ena     : read clock enable
//   addr    : read address
//   data    : registered read data
// ----------------------------------------------------------------------------
module mcload
    import mc_pkg::*;
#(
    parameter int AW  = MC_AW,
    parameter int DW  = MC_DW,
    parameter int BPW = MC_BPW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [AW-1:0] base,
    input  logic [AW:0]   count,
    input  logic [7:0]    s_data,
    input  logic          s_valid,
    output logic          s_ready,
    output logic          busy,
    output logic          done,
    output logic [7:0]    sum,
    input  logic          ena,
    input  logic [AW-1:0] addr,
    output logic [DW-1:0] data
);

    localparam int IW = (BPW > 1) ? $clog2(BPW) : 1;
    localparam logic [IW-1:0] LAST_IDX  = IW'(BPW - 1);
    localparam logic [IW-1:0] IDX_ONE   = IW'(1);
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);
    localparam logic [AW:0]   CNT_ONE   = (AW + 1)'(1);
    localparam logic [AW:0]   CNT_ZERO  = (AW + 1)'(0);
    localparam logic [AW:0]   CNT_FULL  = {1'b1, {AW{1'b0}}};

    mc_state_e       state_r;
    mc_state_e       state_nxt_s;

    logic [AW-1:0]   wptr_r;
    logic [AW:0]     wcnt_r;
    logic [IW-1:0]   bidx_r;
    logic [DW-9:0]   asm_r;
    logic [7:0]      sum_r;

    logic            s_ready_r;
    logic            busy_r;
    logic            done_r;
    logic            s_ready_nxt_s;
    logic            busy_nxt_s;
    logic            done_nxt_s;

    logic            start_acc_s;
    logic            byte_acc_s;
    logic            last_byte_s;
    logic            last_word_s;
    logic [DW-1:0]   wdata_s;

    // s_ready is only high in LOAD, so byte_acc_s is never set elsewhere.
    assign start_acc_s = (state_r == ST_IDLE) && start;
    assign byte_acc_s  = s_valid && s_ready_r;
    assign last_byte_s = byte_acc_s && (bidx_r == LAST_IDX);
    assign last_word_s = last_byte_s && (wcnt_r == CNT_ONE);
    assign wdata_s     = {s_data, asm_r};

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nxt_s = ST_LOAD;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (last_word_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_LOAD;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Output decode from the next state; registered below so each output
    // equals a decode of the current state without any stream-input path.
    always_comb begin
        s_ready_nxt_s = 1'b0;
        busy_nxt_s    = 1'b0;
        done_nxt_s    = 1'b0;
        case (state_nxt_s)
            ST_IDLE: begin
                s_ready_nxt_s = 1'b0;
            end
            ST_LOAD: begin
                s_ready_nxt_s = 1'b1;
                busy_nxt_s    = 1'b1;
            end
            ST_DONE: begin
                done_nxt_s    = 1'b1;
            end
            default: begin
                s_ready_nxt_s = 1'b0;
            end
        endcase
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            s_ready_r <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            s_ready_r <= s_ready_nxt_s;
            busy_r    <= busy_nxt_s;
            done_r    <= done_nxt_s;
        end
    end

    // Loader datapath: pointer, word counter, byte index, assembly, checksum.
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_r <= {AW{1'b0}};
            wcnt_r <= CNT_ZERO;
            bidx_r <= {IW{1'b0}};
            asm_r  <= {(DW-8){1'b0}};
            sum_r  <= 8'd0;
        end else if (start_acc_s) begin
            wptr_r <= base;
            wcnt_r <= (count == CNT_ZERO) ? CNT_FULL : count;
            bidx_r <= {IW{1'b0}};
            asm_r  <= {(DW-8){1'b0}};
            sum_r  <= 8'd0;
        end else if (byte_acc_s) begin
            sum_r <= sum_r + s_data;
            // Shift right so the first byte of a word ends up in bits [7:0].
            asm_r <= {s_data, asm_r[DW-9:8]};
            if (last_byte_s) begin
                bidx_r <= {IW{1'b0}};
                wptr_r <= wptr_r + PTR_ONE;
                wcnt_r <= wcnt_r - CNT_ONE;
            end else begin
                bidx_r <= bidx_r + IDX_ONE;
            end
        end
    end

    mcram_dp #(
        .AW (AW),
        .DW (DW)
    ) u_ram (
        .clk   (clk),
        .reset (reset),
        .we    (last_byte_s),
        .waddr (wptr_r),
        .wdata (wdata_s),
        .ena   (ena),
        .raddr (addr),
        .rdata (data)
    );

    assign s_ready = s_ready_r;
    assign busy    = busy_r;
    assign done    = done_r;
    assign sum     = sum_r;

endmodule

// File: tb/tb_mcload.sv
module tb_mcload;

    logic        clk;
    logic        reset;
    logic        start;
    logic [9:0]  base;
    logic [10:0] count;
    logic [7:0]  s_data;
    logic        s_valid;
    logic        s_ready;
    logic        busy;
    logic        done;
    logic [7:0]  sum;
    logic        ena;
    logic [9:0]  addr;
    logic [55:0] data;

    int checks;
    int errors;

    mcload dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .base    (base),
        .count   (count),
        .s_data  (s_data),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .busy    (busy),
        .done    (done),
        .sum     (sum),
        .ena     (ena),
        .addr    (addr),
        .data    (data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "watchdog");
    end

    task automatic do_start(input logic [9:0] b, input logic [10:0] c);
        base  = b;
        count = c;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        s_data  = b;
        s_valid = 1'b1;
        while (s_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            checks++;
            errors++;
            $display("FAIL send_byte_timeout: s_ready=%b required 1", s_ready);
        end else begin
            @(negedge clk);
        end
        s_valid = 1'b0;
    endtask

    task automatic send_word(input logic [55:0] w);
        for (int j = 0; j < 7; j++) send_byte(w[8*j +: 8]);
    endtask

    task automatic load_word(input logic [9:0] a, input logic [55:0] w);
        do_start(a, 11'd1);
        send_word(w);
        @(negedge clk);
    endtask

    task automatic read_word(input logic [9:0] a, output logic [55:0] d);
        addr = a;
        ena  = 1'b1;
        @(negedge clk);
        ena  = 1'b0;
        d    = data;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL reset_s_ready: got %b exp 0", s_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b exp 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b exp 0", done); end
        checks++; if (sum !== 8'h00) begin errors++; $display("FAIL reset_sum: got %h exp 00", sum); end
        checks++; if (data !== 56'h0) begin errors++; $display("FAIL reset_data: got %h exp 0", data); end
    endtask

    task automatic test_single();
        logic [55:0] d;
        do_start(10'h010, 11'd1);
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL single_ready_rise: got %b exp 1", s_ready); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b exp 1", busy); end
        for (int k = 1; k <= 6; k++) send_byte(8'(k));
        checks++; if (done !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL single_early_done: done=%b busy=%b exp 0/1", done, busy); end
        send_byte(8'h07);
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL single_done_pulse: got %b exp 1", done); end
        checks++; if (busy !== 1'b0 || s_ready !== 1'b0) begin errors++; $display("FAIL single_done_state: busy=%b s_ready=%b exp 0/0", busy, s_ready); end
        checks++; if (sum !== 8'h1C) begin errors++; $display("FAIL single_sum: got %h exp 1c", sum); end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL single_done_width: got %b exp 0", done); end
        read_word(10'h010, d);
        checks++; if (d !== 56'h07060504030201) begin errors++; $display("FAIL single_word: got %h exp 07060504030201", d); end
    endtask

    task automatic test_wrap();
        logic [55:0] d;
        load_word(10'h001, 56'hA1A2A3A4A5A6A7);
        do_start(10'h3FF, 11'd2);
        send_word(56'h11223344556677);
        send_word(56'h8899AABBCCDDEE);
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL wrap_done: got %b exp 1", done); end
        @(negedge clk);
        read_word(10'h3FF, d);
        checks++; if (d !== 56'h11223344556677) begin errors++; $display("FAIL wrap_3ff: got %h exp 11223344556677", d); end
        read_word(10'h000, d);
        checks++; if (d !== 56'h8899AABBCCDDEE) begin errors++; $display("FAIL wrap_000: got %h exp 8899aabbccddee", d); end
        read_word(10'h001, d);
        checks++; if (d !== 56'hA1A2A3A4A5A6A7) begin errors++; $display("FAIL wrap_001_kept: got %h exp a1a2a3a4a5a6a7", d); end
    endtask

    task automatic test_backpressure();
        logic [55:0] exp_w [4];
        logic [55:0] d;
        logic [9:0]  bases [2];
        logic        busy_bad;
        int          gap;
        exp_w[0] = 56'h16151413121110;
        exp_w[1] = 56'h1D1C1B1A191817;
        exp_w[2] = 56'h24232221201F1E;
        exp_w[3] = 56'h2B2A2928272625;
        bases[0] = 10'h100;
        bases[1] = 10'h200;
        for (int r = 0; r < 2; r++) begin
            busy_bad = 1'b0;
            do_start(bases[r], 11'd4);
            for (int k = 0; k < 28; k++) begin
                if (r == 1) begin
                    gap = $urandom_range(0, 3);
                    for (int g = 0; g < gap; g++) begin
                        s_valid = 1'b0;
                        s_data  = 8'hEE;
                        if (busy !== 1'b1) busy_bad = 1'b1;
                        @(negedge clk);
                    end
                end
                if (busy !== 1'b1) busy_bad = 1'b1;
                send_byte(8'h10 + 8'(k));
            end
            checks++; if (busy_bad !== 1'b0) begin errors++; $display("FAIL bp_busy_run%0d: busy dropped=%b exp 0", r, busy_bad); end
            checks++; if (done !== 1'b1) begin errors++; $display("FAIL bp_done_run%0d: got %b exp 1", r, done); end
            checks++; if (sum !== 8'h3A) begin errors++; $display("FAIL bp_sum_run%0d: got %h exp 3a", r, sum); end
            @(negedge clk);
            for (int w = 0; w < 4; w++) begin
                read_word(bases[r] + 10'(w), d);
                checks++; if (d !== exp_w[w]) begin errors++; $display("FAIL bp_word_run%0d_%0d: got %h exp %h", r, w, d, exp_w[w]); end
            end
        end
    endtask

    task automatic test_start_busy();
        logic [55:0] p;
        logic [55:0] q;
        logic [55:0] d;
        p = 56'h37363534333231;
        q = 56'h47464544434241;
        do_start(10'h020, 11'd2);
        for (int j = 0; j < 3; j++) send_byte(p[8*j +: 8]);
        do_start(10'h030, 11'd1);
        for (int j = 3; j < 7; j++) send_byte(p[8*j +: 8]);
        checks++; if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL sb_mid: busy=%b done=%b exp 1/0", busy, done); end
        for (int j = 0; j < 3; j++) send_byte(q[8*j +: 8]);
        checks++; if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL sb_no_restart: busy=%b done=%b exp 1/0", busy, done); end
        for (int j = 3; j < 7; j++) send_byte(q[8*j +: 8]);
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL sb_done: got %b exp 1", done); end
        @(negedge clk);
        read_word(10'h020, d);
        checks++; if (d !== p) begin errors++; $display("FAIL sb_word0: got %h exp %h", d, p); end
        read_word(10'h021, d);
        checks++; if (d !== q) begin errors++; $display("FAIL sb_word1: got %h exp %h", d, q); end
    endtask

    task automatic test_reset_mid();
        logic [55:0] d;
        load_word(10'h041, 56'h5A5A5A5A5A5A5A);
        addr = 10'h041;
        ena  = 1'b1;
        do_start(10'h040, 11'd3);
        send_word(56'h0F0E0D0C0B0A09);
        send_byte(8'hC1);
        send_byte(8'hC2);
        send_byte(8'hC3);
        checks++; if (data !== 56'h5A5A5A5A5A5A5A) begin errors++; $display("FAIL rm_pre_data: got %h exp 5a5a5a5a5a5a5a", data); end
        ena   = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++; if (busy !== 1'b0 || s_ready !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL rm_state: busy=%b s_ready=%b done=%b exp 0/0/0", busy, s_ready, done); end
        checks++; if (sum !== 8'h00) begin errors++; $display("FAIL rm_sum: got %h exp 00", sum); end
        checks++; if (data !== 56'h0) begin errors++; $display("FAIL rm_data: got %h exp 0", data); end
        read_word(10'h040, d);
        checks++; if (d !== 56'h0F0E0D0C0B0A09) begin errors++; $display("FAIL rm_word1_kept: got %h exp 0f0e0d0c0b0a09", d); end
        read_word(10'h041, d);
        checks++; if (d !== 56'h5A5A5A5A5A5A5A) begin errors++; $display("FAIL rm_word2_unchanged: got %h exp 5a5a5a5a5a5a5a", d); end
    endtask

    task automatic test_collision();
        load_word(10'h050, 56'h13579BDF02468A);
        addr = 10'h050;
        ena  = 1'b1;
        do_start(10'h050, 11'd1);
        send_word(56'hFEDCBA98765432);
        checks++; if (data !== 56'h13579BDF02468A) begin errors++; $display("FAIL coll_old: got %h exp 13579bdf02468a", data); end
        @(negedge clk);
        checks++; if (data !== 56'hFEDCBA98765432) begin errors++; $display("FAIL coll_new: got %h exp fedcba98765432", data); end
        ena = 1'b0;
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        reset   = 1'b1;
        start   = 1'b0;
        base    = 10'h000;
        count   = 11'd0;
        s_data  = 8'h00;
        s_valid = 1'b0;
        ena     = 1'b0;
        addr    = 10'h000;
        @(negedge clk);
        test_reset();
        test_single();
        test_wrap();
        test_backpressure();
        test_start_busy();
        test_reset_mid();
        test_collision();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
